// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard/handshake bundle between the core datapath and pipeline_ctrl
interface pipeline_ctrl_if #(
    parameter int CNTW = 32
);
    logic            ihit;
    logic            dhit;
    logic [4:0]      rs_out_1;
    logic [4:0]      rt_out_1;
    logic [4:0]      wsel_out_2;
    logic            dREN_out_2;
    logic            dREN_out_3;
    logic            dWEN_out_3;
    logic            branch_out_3;
    logic            halt_out_4;

    logic            pc_en;
    logic            ifid_en;
    logic            idex_en;
    logic            exmem_en;
    logic            memwb_en;
    logic            ifid_flush;
    logic            idex_flush;
    logic            exmem_flush;
    logic            halt;
    logic [CNTW-1:0] stall_cnt;
    logic [CNTW-1:0] flush_cnt;

    // Core datapath side: reports pipeline conditions, consumes enables.
    modport master (
        output ihit, dhit, rs_out_1, rt_out_1, wsel_out_2, dREN_out_2,
               dREN_out_3, dWEN_out_3, branch_out_3, halt_out_4,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halt, stall_cnt, flush_cnt
    );

    // Controller side.
    modport slave (
        input  ihit, dhit, rs_out_1, rt_out_1, wsel_out_2, dREN_out_2,
               dREN_out_3, dWEN_out_3, branch_out_3, halt_out_4,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halt, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - 5-stage pipeline stall/flush sequencer with halt flag and perf counters
module pipeline_ctrl #(
    parameter int CPUID = 0,
    parameter int CNTW  = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    pipeline_ctrl_if.slave    bus
);
    if (CNTW < 1 || CPUID < 0) begin : g_bad_params
        $error("pipeline_ctrl: invalid parameters");
    end

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } state_t;

    // Control word: {pc, ifid, idex, exmem, memwb enables, ifid, idex, exmem flushes}
    localparam logic [7:0] CTL_FREEZE = 8'b00000_000;
    localparam logic [7:0] CTL_BRANCH = 8'b11111_111;
    localparam logic [7:0] CTL_LDUSE  = 8'b00111_010;
    localparam logic [7:0] CTL_IMISS  = 8'b01111_100;
    localparam logic [7:0] CTL_NORMAL = 8'b11111_000;
    localparam logic [CNTW-1:0] ONE   = {{(CNTW-1){1'b0}}, 1'b1};

    state_t          state;
    logic            halt_q;
    logic [CNTW-1:0] stall_q;
    logic [CNTW-1:0] flush_q;

    logic            mem_req;
    logic            mem_ok;
    logic            load_use;
    logic            do_flush;
    logic [7:0]      ctl;

    always_comb begin
        mem_req  = bus.dREN_out_3 | bus.dWEN_out_3;
        mem_ok   = !mem_req | bus.dhit;
        load_use = bus.dREN_out_2 && (bus.wsel_out_2 != 5'd0) &&
                   ((bus.wsel_out_2 == bus.rs_out_1) || (bus.wsel_out_2 == bus.rt_out_1));
        ctl      = CTL_FREEZE;
        do_flush = 1'b0;
        if (state != HALTED) begin
            if (!mem_ok) begin
                ctl = CTL_FREEZE;
            end else if (bus.branch_out_3) begin
                ctl      = CTL_BRANCH;
                do_flush = 1'b1;
            end else if (load_use) begin
                ctl = CTL_LDUSE;
            end else if (!bus.ihit) begin
                ctl = CTL_IMISS;
            end else begin
                ctl = CTL_NORMAL;
            end
        end
    end

    // Reset gates the enables directly so latches hold even before the first edge.
    assign bus.pc_en       = ctl[7] & nRST;
    assign bus.ifid_en     = ctl[6] & nRST;
    assign bus.idex_en     = ctl[5] & nRST;
    assign bus.exmem_en    = ctl[4] & nRST;
    assign bus.memwb_en    = ctl[3] & nRST;
    assign bus.ifid_flush  = ctl[2] & nRST;
    assign bus.idex_flush  = ctl[1] & nRST;
    assign bus.exmem_flush = ctl[0] & nRST;
    assign bus.halt        = halt_q;
    assign bus.stall_cnt   = stall_q;
    assign bus.flush_cnt   = flush_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= RUN;
            halt_q  <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.halt_out_4 && mem_ok) begin
                        state  <= HALTED;
                        halt_q <= 1'b1;
                    end else if (mem_req && !bus.dhit) begin
                        state <= DWAIT;
                    end
                end
                DWAIT: begin
                    if (bus.halt_out_4 && mem_ok) begin
                        state  <= HALTED;
                        halt_q <= 1'b1;
                    end else if (bus.dhit) begin
                        state <= RUN;
                    end
                end
                HALTED: begin
                    state  <= HALTED;
                    halt_q <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase

            if (state != HALTED) begin
                if (!ctl[7]) begin
                    stall_q <= stall_q + ONE;
                end
                if (do_flush) begin
                    flush_q <= flush_q + ONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - vector table plus corner sequences for pipeline_ctrl, scoreboard checked
module tb_pipeline_ctrl;
    localparam int CNTW = 16;

    localparam logic [7:0] FRZ = 8'h00;
    localparam logic [7:0] BRF = 8'hFF;
    localparam logic [7:0] LDU = 8'h3A;
    localparam logic [7:0] IMS = 8'h7C;
    localparam logic [7:0] NRM = 8'hF8;

    typedef struct packed {
        logic       ihit;
        logic       dhit;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wsel;
        logic       dren2;
        logic       dren3;
        logic       dwen3;
        logic       br;
        logic       halt4;
        logic [7:0] ctl;
    } vec_t;

    typedef struct packed {
        logic [7:0]      ctl;
        logic            halt;
        logic [CNTW-1:0] stall;
        logic [CNTW-1:0] flush;
    } exp_t;

    logic CLK;
    logic nRST;

    pipeline_ctrl_if #(.CNTW(CNTW)) bus ();

    pipeline_ctrl #(.CPUID(0), .CNTW(CNTW)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    exp_t            sb[$];
    int              n_vec;
    int              n_err;
    logic            m_halted;
    logic [CNTW-1:0] m_stall;
    logic [CNTW-1:0] m_flush;
    vec_t            tbl[15];

    function automatic vec_t mk(logic ih, logic dh, logic [4:0] rs, logic [4:0] rt,
                                logic [4:0] ws, logic dr2, logic dr3, logic dw3,
                                logic br, logic h4, logic [7:0] c);
        vec_t v;
        v.ihit = ih;  v.dhit = dh;  v.rs = rs;  v.rt = rt;  v.wsel = ws;
        v.dren2 = dr2; v.dren3 = dr3; v.dwen3 = dw3; v.br = br; v.halt4 = h4;
        v.ctl = c;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.ihit         = v.ihit;
        bus.dhit         = v.dhit;
        bus.rs_out_1     = v.rs;
        bus.rt_out_1     = v.rt;
        bus.wsel_out_2   = v.wsel;
        bus.dREN_out_2   = v.dren2;
        bus.dREN_out_3   = v.dren3;
        bus.dWEN_out_3   = v.dwen3;
        bus.branch_out_3 = v.br;
        bus.halt_out_4   = v.halt4;
    endtask

    task automatic push_exp(input logic [7:0] c);
        exp_t e;
        e.ctl   = m_halted ? FRZ : c;
        e.halt  = m_halted;
        e.stall = m_stall;
        e.flush = m_flush;
        sb.push_back(e);
    endtask

    task automatic check(input string name);
        exp_t       e;
        logic [7:0] act;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e   = sb.pop_front();
            act = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                   bus.ifid_flush, bus.idex_flush, bus.exmem_flush};
            n_vec++;
            if (act !== e.ctl) begin
                n_err++;
                $display("FAIL %s ctl: got %08b want %08b", name, act, e.ctl);
            end
            n_vec++;
            if (bus.halt !== e.halt) begin
                n_err++;
                $display("FAIL %s halt: got %b want %b", name, bus.halt, e.halt);
            end
            n_vec++;
            if (bus.stall_cnt !== e.stall) begin
                n_err++;
                $display("FAIL %s stall_cnt: got %0d want %0d", name, bus.stall_cnt, e.stall);
            end
            n_vec++;
            if (bus.flush_cnt !== e.flush) begin
                n_err++;
                $display("FAIL %s flush_cnt: got %0d want %0d", name, bus.flush_cnt, e.flush);
            end
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        logic [7:0] c;
        @(posedge CLK);
        #1;
        drive(v);
        c = m_halted ? FRZ : v.ctl;
        push_exp(v.ctl);
        @(negedge CLK);
        check(name);
        if (!m_halted) begin
            if (!c[7]) m_stall = m_stall + 1'b1;
            if (c == BRF) m_flush = m_flush + 1'b1;
            if (v.halt4 && (!(v.dren3 || v.dwen3) || v.dhit)) m_halted = 1'b1;
        end
    endtask

    task automatic reset_now(input string name);
        @(posedge CLK);
        #1;
        drive(mk(1, 1, 1, 2, 3, 0, 0, 0, 0, 0, NRM));
        #1;
        push_exp(NRM);
        check({name, "_pre"});
        #1;
        nRST = 1'b0;
        #1;
        m_halted = 1'b0;
        m_stall  = '0;
        m_flush  = '0;
        push_exp(FRZ);
        check(name);
        @(negedge CLK);
        #2;
        nRST = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec    = 0;
        n_err    = 0;
        m_halted = 1'b0;
        m_stall  = '0;
        m_flush  = '0;

        tbl[0]  = mk(1, 0, 1, 2, 3, 1, 0, 0, 0, 0, NRM);
        tbl[1]  = mk(1, 1, 2, 7, 2, 1, 0, 0, 0, 0, LDU);
        tbl[2]  = mk(1, 1, 9, 5, 5, 1, 0, 0, 0, 0, LDU);
        tbl[3]  = mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, NRM);
        tbl[4]  = mk(1, 1, 4, 4, 4, 0, 0, 0, 0, 0, NRM);
        tbl[5]  = mk(0, 1, 1, 2, 3, 0, 0, 0, 0, 0, IMS);
        tbl[6]  = mk(0, 0, 6, 1, 6, 1, 0, 0, 0, 0, LDU);
        tbl[7]  = mk(0, 0, 6, 1, 6, 1, 0, 0, 1, 0, BRF);
        tbl[8]  = mk(1, 0, 1, 2, 3, 0, 1, 0, 0, 0, FRZ);
        tbl[9]  = mk(1, 0, 1, 2, 3, 0, 1, 0, 1, 0, FRZ);
        tbl[10] = mk(0, 1, 1, 2, 3, 0, 1, 0, 1, 0, BRF);
        tbl[11] = mk(1, 1, 1, 2, 3, 0, 0, 1, 0, 0, NRM);
        tbl[12] = mk(0, 0, 3, 8, 3, 1, 0, 1, 0, 0, FRZ);
        tbl[13] = mk(1, 0, 1, 2, 3, 0, 0, 0, 0, 0, NRM);
        tbl[14] = mk(1, 1, 1, 2, 3, 0, 0, 0, 0, 0, NRM);

        nRST = 1'b0;
        drive(mk(1, 1, 1, 2, 3, 0, 0, 0, 0, 0, NRM));
        #3;
        push_exp(FRZ);
        check("reset_hold");
        #9;
        nRST = 1'b1;

        for (int i = 0; i < 15; i++) begin
            apply(tbl[i], $sformatf("tbl%0d", i));
        end

        // Load-use bubble, then the load has moved to MEM and the pair no longer stalls.
        reset_now("rst_a");
        apply(mk(1, 1, 2, 0, 2, 1, 0, 0, 0, 0, LDU), "lu_bubble");
        apply(mk(1, 1, 2, 0, 4, 0, 1, 0, 0, 0, NRM), "lu_after");

        // Dcache miss of 4 cycles, dhit cycle with an icache miss also stalls the PC.
        reset_now("rst_b");
        for (int i = 0; i < 4; i++) begin
            apply(mk(1, 0, 1, 2, 3, 0, 1, 0, 0, 0, FRZ), $sformatf("dmiss%0d", i));
        end
        apply(mk(0, 1, 1, 2, 3, 0, 1, 0, 0, 0, IMS), "dmiss_hit");
        apply(mk(1, 1, 1, 2, 3, 0, 0, 0, 0, 0, NRM), "dmiss_cnt");

        // Branch held behind a store miss.
        apply(mk(1, 0, 1, 2, 3, 0, 0, 1, 1, 0, FRZ), "br_miss0");
        apply(mk(1, 0, 1, 2, 3, 0, 0, 1, 1, 0, FRZ), "br_miss1");
        apply(mk(1, 1, 1, 2, 3, 0, 0, 1, 1, 0, BRF), "br_miss_hit");

        // Halt waits for mem_ok, then everything freezes.
        apply(mk(1, 0, 1, 2, 3, 0, 1, 0, 0, 1, FRZ), "halt_blocked");
        apply(mk(1, 1, 1, 2, 3, 0, 1, 0, 0, 1, NRM), "halt_take");
        apply(mk(1, 1, 1, 2, 3, 0, 0, 0, 1, 0, BRF), "halted0");
        apply(mk(0, 1, 1, 2, 3, 0, 0, 0, 0, 0, IMS), "halted1");
        apply(mk(1, 1, 1, 2, 3, 0, 0, 0, 0, 0, NRM), "halted2");

        reset_now("rst_halted");
        apply(mk(1, 1, 1, 2, 3, 0, 0, 0, 0, 0, NRM), "post_halt_run");

        // Reset asserted while a dcache access is outstanding.
        apply(mk(0, 0, 1, 2, 3, 0, 1, 0, 0, 0, FRZ), "pre_dwait");
        reset_now("rst_dwait");
        apply(mk(0, 1, 1, 2, 3, 0, 0, 0, 0, 0, IMS), "post_dwait0");
        apply(mk(1, 1, 7, 2, 7, 1, 0, 0, 0, 0, LDU), "post_dwait1");
        apply(mk(1, 1, 1, 2, 3, 0, 0, 0, 0, 0, NRM), "post_dwait2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
